// File: rtl/mem_scan_reader.sv
// Read-side scanner for a small synchronous RAM: walks every address once per start,
// presents each word on a display bus and accumulates a running sum and maximum.
module mem_scan_reader #(
    parameter int unsigned ADDR_WIDTH  = 2,
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic                             clk_2,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    output logic                             mem_rd,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic [ADDR_WIDTH-1:0]            dout_addr,
    output logic                             dout_valid,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum,
    output logic [DATA_WIDTH-1:0]            max_val,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned SUM_WIDTH = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0]  HOLD_INIT = CNT_WIDTH'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StCapture,
        StHold,
        StDone
    } state_e;

    state_e               state;
    logic [CNT_WIDTH-1:0] hold_cnt;
    logic                 at_last;
    logic [SUM_WIDTH-1:0] rdata_ext;

    // mem_addr doubles as the scan pointer; it only changes between reads.
    assign at_last   = (mem_addr == LAST_ADDR);
    assign rdata_ext = SUM_WIDTH'(mem_rdata);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            hold_cnt   <= '0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            sum        <= '0;
            max_val    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            case (state)
                StIdle: begin
                    // abort is ignored here, so start wins even when both are high
                    if (start) begin
                        state    <= StIssue;
                        mem_addr <= '0;
                        sum      <= '0;
                        max_val  <= '0;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                StIssue: begin
                    mem_rd <= 1'b0;
                    if (abort) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        state <= StCapture;
                    end
                end

                StCapture: begin
                    if (abort) begin
                        // in-flight read is dropped: no dout update, no accumulation
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        dout       <= mem_rdata;
                        dout_addr  <= mem_addr;
                        dout_valid <= 1'b1;
                        sum        <= sum + rdata_ext;
                        if (mem_rdata > max_val) begin
                            max_val <= mem_rdata;
                        end
                        if (HOLD_CYCLES > 0) begin
                            state    <= StHold;
                            hold_cnt <= HOLD_INIT;
                        end else if (at_last) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= StIssue;
                            mem_addr <= mem_addr + 1'b1;
                            mem_rd   <= 1'b1;
                        end
                    end
                end

                StHold: begin
                    if (abort) begin
                        state    <= StIdle;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                        if (hold_cnt <= CNT_ONE) begin
                            if (at_last) begin
                                state <= StDone;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= StIssue;
                                mem_addr <= mem_addr + 1'b1;
                                mem_rd   <= 1'b1;
                            end
                        end
                    end
                end

                StDone: begin
                    // wait for start to drop so a held start cannot re-trigger a scan
                    if (abort || !start) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state  <= StIdle;
                    mem_rd <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    a_rd_single: assert property (@(posedge clk_2) disable iff (reset) mem_rd |=> !mem_rd);
    a_busy_done: assert property (@(posedge clk_2) disable iff (reset) !(busy && done));

endmodule

// File: doc/mem_scan_reader.md
Name: mem_scan_reader

Overview:
- Read-side initiator for the small synchronous R/W RAM (ADDR_WIDTH x DATA_WIDTH, 1-cycle registered read) that the switch-driven write path fills.
- On start, it walks every address in order and issues one read per word.
- Each returned word is presented on a display bus for a programmable hold time.
- A running sum and maximum are accumulated for LED/SEG/LCD display in top.

Parameters:
- ADDR_WIDTH, 2, RAM address width; the scan covers addresses 0 .. 2**ADDR_WIDTH-1.
- DATA_WIDTH, 4, RAM word width.
- HOLD_CYCLES, 0, extra cycles each word stays on dout before the next read issues (0 = back-to-back).

Ports:
- clk_2  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE, high begins a scan.
- abort  in  1  synchronous; high in any non-IDLE state returns the FSM to IDLE next edge.
- mem_rd  out  1  read strobe to RAM, high exactly one cycle per word.
- mem_addr  out  ADDR_WIDTH  RAM address, valid while mem_rd is high.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after mem_rd.
- dout  out  DATA_WIDTH  last word read.
- dout_addr  out  ADDR_WIDTH  address of dout.
- dout_valid  out  1  one-cycle pulse when dout/dout_addr update.
- sum  out  DATA_WIDTH+ADDR_WIDTH  sum of words read in the current scan.
- max_val  out  DATA_WIDTH  largest word read in the current scan.
- busy  out  1  high in ISSUE, CAPTURE and HOLD.
- done  out  1  high while in DONE.

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs 0: mem_rd, mem_addr, dout, dout_addr, dout_valid, sum, max_val, busy, done. Hold counter 0.
- All outputs are registered or decoded from state; nothing depends combinationally on start.
- States: IDLE, ISSUE, CAPTURE, HOLD, DONE.
- IDLE: if start=1, go to ISSUE, set addr=0, sum=0, max_val=0. Otherwise stay. dout and dout_addr retain their last values.
- ISSUE: mem_rd=1, mem_addr=addr. Go to CAPTURE.
- CAPTURE: mem_rdata is valid this cycle. On the exit edge:
  - dout<=mem_rdata, dout_addr<=addr, dout_valid<=1 for one cycle.
  - sum<=sum+mem_rdata, zero-extended; cannot overflow, max is (2**ADDR_WIDTH)*(2**DATA_WIDTH-1).
  - max_val<=max(max_val, mem_rdata), unsigned compare.
  - Next state: if HOLD_CYCLES>0, go to HOLD with counter=HOLD_CYCLES. Else if addr is the last address, go to DONE. Else addr+1 and go to ISSUE.
- HOLD: decrement counter each cycle. When counter reaches 1, go to ISSUE with addr+1, or to DONE if addr is the last address. Stays exactly HOLD_CYCLES cycles.
- DONE: done=1. sum and max_val are final. Go to IDLE only when start=0, so a held start produces a single scan with no auto-repeat.
- Timing: if start is seen at edge E0, word k's mem_rd is high in cycle k*(2+HOLD_CYCLES) after E0. DONE is entered at E0 + N*(2+HOLD_CYCLES), N=2**ADDR_WIDTH. The last dout_valid coincides with the first done cycle when HOLD_CYCLES=0.
- Address wrap: addr never increments past the last address; the scan terminates instead.
- abort: in ISSUE, CAPTURE, HOLD or DONE, go to IDLE next edge, mem_rd=0, done=0. Partial sum/max_val are kept. A read already in flight (abort in CAPTURE) is discarded, no dout_valid. abort has priority over all transitions except reset. abort is ignored in IDLE.
- start=1 together with abort=1 in IDLE: the scan starts.
- Reset mid-scan clears everything immediately; the RAM contents are untouched.

Test Plan:
- RAM={3,0xF,7,1}, HOLD_CYCLES=0, start pulse: mem_rd at cycles 0,2,4,6 with addr 0..3. dout_valid pulses carry 3,F,7,1. done at cycle 8 with sum=0x1A, max_val=0xF.
- All words 0xF: sum=0x3C (no overflow), max_val=0xF. All words 0: sum=0, max_val=0, four dout_valid pulses.
- HOLD_CYCLES=2, RAM={1,2,3,4}: dout_valid spaced 4 cycles apart, done at cycle 16, sum=0x0A, max_val=4.
- start held high 30 cycles: exactly one scan (4 mem_rd pulses). done stays 1 until start drops, then IDLE. A second start yields the same results.
- abort asserted in the CAPTURE of addr 2 (RAM={3,0xF,7,1}): no dout_valid for addr 2, IDLE next cycle, sum=0x12, max_val=0xF, done never asserts.
- reset pulsed mid-HOLD: all outputs 0 immediately, no further mem_rd. After release, start gives a full correct scan.
